// File: rtl/prog_mem_pkg.sv
// prog_mem_pkg: shared state enum, opcodes and default program image
package prog_mem_pkg;
  typedef enum logic [1:0] {RUN, DRAIN, PROG} state_t;
  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LOAD = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_JMP = 4'h6;
  localparam logic [3:0] OP_OUT = 4'h8;
  localparam int DEFAULT_LEN = 5;
  localparam logic [15:0] DEFAULT_PROG [DEFAULT_LEN] = '{
    {OP_LOAD, 12'h001},
    {OP_OUT, 12'h000},
    {OP_ADD, 12'h001},
    {OP_OUT, 12'h000},
    {OP_JMP, 12'h001}
  };
endpackage

// File: rtl/prog_mem_if.sv
// prog_mem_if: fetch, return and program-load signals of the program memory
interface prog_mem_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
);
  logic fetch_valid;
  logic [ADDR_W-1:0] fetch_addr;
  logic fetch_ready;
  logic rdata_valid;
  logic [DATA_W-1:0] rdata;
  logic rdata_err;
  logic rdata_ready;
  logic prog_en;
  logic prog_we;
  logic [ADDR_W-1:0] prog_addr;
  logic [DATA_W-1:0] prog_data;
  logic prog_mode;
  modport master (
    output fetch_valid, fetch_addr, rdata_ready, prog_en, prog_we, prog_addr, prog_data,
    input fetch_ready, rdata_valid, rdata, rdata_err, prog_mode
  );
  modport slave (
    input fetch_valid, fetch_addr, rdata_ready, prog_en, prog_we, prog_addr, prog_data,
    output fetch_ready, rdata_valid, rdata, rdata_err, prog_mode
  );
endinterface

// File: rtl/prog_mem_array.sv
// prog_mem_array: DEPTH x DATA_W storage, sync write, combinational read, out-of-range guarded
module prog_mem_array import prog_mem_pkg::*; #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16,
  parameter int DEPTH = 256
) (
  input  logic clk,
  input  logic we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata,
  output logic rerr
);
  localparam int IW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  // Default words keep their opcode in the top nibble and immediate in the low byte
  function automatic logic [DATA_W-1:0] widen(logic [15:0] w);
    widen = '0;
    widen[DATA_W-1 -: 4] = w[15:12];
    widen[7:0] = w[7:0];
  endfunction
  logic [DATA_W-1:0] mem [DEPTH] = '{
    0: widen(DEFAULT_PROG[0]),
    1: widen(DEFAULT_PROG[1]),
    2: widen(DEFAULT_PROG[2]),
    3: widen(DEFAULT_PROG[3]),
    4: widen(DEFAULT_PROG[4]),
    default: '0
  };
  logic w_in, r_in;
  assign w_in = 32'(waddr) < DEPTH;
  assign r_in = 32'(raddr) < DEPTH;
  // Writes beyond DEPTH are dropped so they cannot alias onto low words
  always_ff @(posedge clk)
    if (we && w_in) mem[waddr[IW-1:0]] <= wdata;
  // Out-of-range reads return a NOP and flag the error
  always_comb begin
    rerr = !r_in;
    rdata = r_in ? mem[raddr[IW-1:0]] : '0;
  end
endmodule

// File: rtl/prog_mem.sv
// prog_mem: instruction memory with fetch/return handshake and program-load mode
module prog_mem import prog_mem_pkg::*; #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16,
  parameter int DEPTH = 256
) (
  input logic clk,
  input logic rst,
  prog_mem_if.slave bus
);
  state_t state, state_nx;
  logic accept, out_free, mem_we, mem_err;
  logic [DATA_W-1:0] mem_rd;
  assign out_free = !bus.rdata_valid || bus.rdata_ready;
  assign accept = bus.fetch_valid && bus.fetch_ready;
  assign mem_we = bus.prog_we && state == PROG && !rst;
  prog_mem_array #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) u_array (
    .clk(clk),
    .we(mem_we),
    .waddr(bus.prog_addr),
    .wdata(bus.prog_data),
    .raddr(bus.fetch_addr),
    .rdata(mem_rd),
    .rerr(mem_err)
  );
  // State register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= RUN;
    else state <= state_nx;
  // Program mode waits for any held word to be taken before entering PROG
  always_comb
    state_nx = state == RUN ? (bus.prog_en ? (out_free ? PROG : DRAIN) : RUN) :
               state == DRAIN ? (bus.rdata_ready ? PROG : DRAIN) :
               (bus.prog_en ? PROG : RUN);
  // Fetch is accepted only in RUN with no pending mode change and room at the output
  always_comb begin
    bus.prog_mode = state == PROG;
    bus.fetch_ready = state == RUN && !bus.prog_en && out_free;
  end
  // Return register: loads on accept, holds while stalled, empties after handshake
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      bus.rdata_valid <= 1'b0;
      bus.rdata <= '0;
      bus.rdata_err <= 1'b0;
    end else if (accept) begin
      bus.rdata_valid <= 1'b1;
      bus.rdata <= mem_rd;
      bus.rdata_err <= mem_err;
    end else if (bus.rdata_ready) begin
      bus.rdata_valid <= 1'b0;
    end
endmodule

// File: tb/tb_prog_mem.sv
// tb_prog_mem: vector table, directed corner sequences and random model check for prog_mem
module tb_prog_mem;
  localparam int D = 16;
  logic clk = 1'b0;
  logic rst;
  int errors = 0;
  int checks = 0;
  logic [15:0] mm [256];
  prog_mem_if #(.ADDR_W(8), .DATA_W(16)) bus ();
  prog_mem #(.ADDR_W(8), .DATA_W(16), .DEPTH(D)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;
  typedef struct {
    logic [7:0] addr;
    logic [15:0] data;
    logic err;
  } vec_t;
  vec_t tv [10];
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  function automatic logic [15:0] exp_word(logic [7:0] a);
    return a < D ? mm[a] : 16'h0;
  endfunction
  initial begin
    logic pe, fr, acc, m_v, m_e, wr;
    logic [15:0] m_d, n_d;
    logic [7:0] wa;
    logic [15:0] wd;
    int m_mode, n_mode;
    foreach (mm[i]) mm[i] = 16'h0;
    mm[0] = 16'h1001; mm[1] = 16'h8000; mm[2] = 16'h2001; mm[3] = 16'h8000; mm[4] = 16'h6001;
    tv[0] = '{8'h00, 16'h1001, 1'b0};
    tv[1] = '{8'h01, 16'h8000, 1'b0};
    tv[2] = '{8'h02, 16'h2001, 1'b0};
    tv[3] = '{8'h03, 16'h8000, 1'b0};
    tv[4] = '{8'h04, 16'h6001, 1'b0};
    tv[5] = '{8'h05, 16'h0000, 1'b0};
    tv[6] = '{8'h0F, 16'h0000, 1'b0};
    tv[7] = '{8'h10, 16'h0000, 1'b1};
    tv[8] = '{8'h20, 16'h0000, 1'b1};
    tv[9] = '{8'hFF, 16'h0000, 1'b1};
    rst = 1'b1;
    bus.fetch_valid = 0; bus.fetch_addr = 0; bus.rdata_ready = 1;
    bus.prog_en = 0; bus.prog_we = 0; bus.prog_addr = 0; bus.prog_data = 0;
    #2;
    chk("rst_valid", bus.rdata_valid, 0);
    chk("rst_rdata", bus.rdata, 0);
    chk("rst_err", bus.rdata_err, 0);
    chk("rst_mode", bus.prog_mode, 0);
    step();
    rst = 1'b0;
    #1;
    chk("run_fetch_ready", bus.fetch_ready, 1);
    for (int i = 0; i < 10; i++) begin
      bus.fetch_valid = 1; bus.fetch_addr = tv[i].addr;
      step();
      chk($sformatf("tbl_valid_%0d", i), bus.rdata_valid, 1);
      chk($sformatf("tbl_rdata_%0d", i), bus.rdata, tv[i].data);
      chk($sformatf("tbl_err_%0d", i), bus.rdata_err, tv[i].err);
    end
    bus.fetch_valid = 0;
    step();
    chk("drain_empty", bus.rdata_valid, 0);
    bus.rdata_ready = 0; bus.fetch_valid = 1; bus.fetch_addr = 2;
    step();
    chk("stall_load", bus.rdata, 16'h2001);
    bus.fetch_addr = 3;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_fetch_ready", bus.fetch_ready, 0);
      step();
      chk("stall_hold_rdata", bus.rdata, 16'h2001);
      chk("stall_hold_valid", bus.rdata_valid, 1);
    end
    bus.rdata_ready = 1; bus.fetch_valid = 0;
    #1;
    chk("stall_release_ready", bus.fetch_ready, 1);
    step();
    chk("stall_one_transfer", bus.rdata_valid, 0);
    bus.rdata_ready = 0; bus.fetch_valid = 1; bus.fetch_addr = 0;
    step();
    bus.fetch_valid = 0; bus.prog_en = 1;
    #1;
    chk("drain_fetch_ready", bus.fetch_ready, 0);
    step();
    chk("drain_mode", bus.prog_mode, 0);
    chk("drain_valid", bus.rdata_valid, 1);
    step();
    chk("drain_still", bus.prog_mode, 0);
    bus.rdata_ready = 1;
    step();
    chk("prog_entered", bus.prog_mode, 1);
    chk("prog_valid_low", bus.rdata_valid, 0);
    bus.prog_we = 1; bus.prog_addr = 0; bus.prog_data = 16'h1005;
    step();
    bus.prog_addr = 8'd20; bus.prog_data = 16'h1234;
    step();
    bus.prog_en = 0; bus.prog_addr = 3; bus.prog_data = 16'h3003;
    step();
    bus.prog_we = 0;
    mm[0] = 16'h1005; mm[3] = 16'h3003;
    chk("prog_exit", bus.prog_mode, 0);
    bus.fetch_valid = 1; bus.fetch_addr = 0;
    step();
    chk("prog_new_w0", bus.rdata, 16'h1005);
    bus.fetch_addr = 3;
    step();
    chk("prog_last_cycle_w3", bus.rdata, 16'h3003);
    bus.fetch_addr = 4;
    step();
    chk("prog_oob_no_alias", bus.rdata, 16'h6001);
    bus.fetch_valid = 0; bus.prog_we = 1; bus.prog_addr = 1; bus.prog_data = 16'hFFFF;
    step();
    bus.prog_we = 0; bus.fetch_valid = 1; bus.fetch_addr = 1;
    step();
    chk("run_we_ignored", bus.rdata, 16'h8000);
    bus.fetch_valid = 0;
    step();
    pe = 0; m_mode = 0; m_v = 0; m_d = 0; m_e = 0;
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(9) == 0) pe = !pe;
      bus.prog_en = pe;
      bus.fetch_valid = 1'($urandom_range(1));
      bus.fetch_addr = 8'($urandom_range(31));
      bus.rdata_ready = $urandom_range(3) != 0;
      bus.prog_we = 1'($urandom_range(1));
      bus.prog_addr = 8'($urandom_range(31));
      bus.prog_data = 16'($urandom);
      #1;
      fr = m_mode == 0 && !pe && (!m_v || bus.rdata_ready);
      chk("rnd_fetch_ready", bus.fetch_ready, fr);
      chk("rnd_mode", bus.prog_mode, m_mode == 2);
      acc = bus.fetch_valid && fr;
      n_d = exp_word(bus.fetch_addr);
      wr = m_mode == 2 && bus.prog_we && bus.prog_addr < D;
      wa = bus.prog_addr; wd = bus.prog_data;
      n_mode = m_mode;
      if (m_mode == 0 && pe) n_mode = (m_v && !bus.rdata_ready) ? 1 : 2;
      else if (m_mode == 1 && bus.rdata_ready) n_mode = 2;
      else if (m_mode == 2 && !pe) n_mode = 0;
      if (acc) begin
        m_v = 1; m_d = n_d; m_e = bus.fetch_addr >= D;
      end else if (bus.rdata_ready) m_v = 0;
      if (wr) mm[wa] = wd;
      m_mode = n_mode;
      step();
      chk("rnd_valid", bus.rdata_valid, m_v);
      if (m_v) begin
        chk("rnd_rdata", bus.rdata, m_d);
        chk("rnd_err", bus.rdata_err, m_e);
      end
    end
    bus.prog_en = 0; bus.fetch_valid = 0; bus.prog_we = 0; bus.rdata_ready = 1;
    repeat (3) step();
    bus.prog_en = 1;
    step();
    bus.prog_we = 1; bus.prog_addr = 2; bus.prog_data = 16'hABCD;
    step();
    bus.prog_en = 0; bus.prog_we = 0;
    step();
    mm[2] = 16'hABCD;
    bus.rdata_ready = 0; bus.fetch_valid = 1; bus.fetch_addr = 0;
    step();
    chk("pre_rst_valid", bus.rdata_valid, 1);
    bus.fetch_valid = 0;
    #3;
    rst = 1;
    #1;
    chk("async_rst_valid", bus.rdata_valid, 0);
    chk("async_rst_rdata", bus.rdata, 0);
    chk("async_rst_err", bus.rdata_err, 0);
    chk("async_rst_mode", bus.prog_mode, 0);
    step();
    rst = 0; bus.rdata_ready = 1; bus.prog_en = 1;
    step();
    chk("prog_before_rst", bus.prog_mode, 1);
    bus.prog_we = 1; bus.prog_addr = 0; bus.prog_data = 16'hDEAD;
    #2;
    rst = 1;
    #1;
    chk("rst_mid_prog_mode", bus.prog_mode, 0);
    step();
    rst = 0; bus.prog_we = 0; bus.prog_en = 0;
    bus.fetch_valid = 1; bus.fetch_addr = 0;
    step();
    chk("post_rst_w0", bus.rdata, mm[0]);
    bus.fetch_addr = 2;
    step();
    chk("post_rst_w2", bus.rdata, 16'hABCD);
    bus.fetch_valid = 0;
    step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
